imm_decode_ctrl: RTL

- ID-stage controller that sequences the immediate-extension datapath of the pipelined MIPS core.
- Accepts instructions from IF/ID over a valid/ready handshake and selects the extension mode from the opcode: sign, zero, LUI or jump.
- Registers the extended 32-bit immediate plus register fields into ID/EX.
- Inserts load-use bubbles and honours pipeline flush.

---
 rtl/imm_decode_ctrl_if.sv | 32 +++
 rtl/imm_decode_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_ctrl_if.sv
// Handshake and bus signals between IF/ID, the immediate-decode controller and EX.
interface imm_decode_ctrl_if #(
  parameter int unsigned REG_W = 5
);
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned MODE_W  = 3;

  logic                 in_valid;
  logic                 in_ready;
  logic [INSTR_W-1:0]   in_instr;
  logic                 flush;
  logic                 ex_memread;
  logic [REG_W-1:0]     ex_rt;
  logic                 out_valid;
  logic                 out_ready;
  logic [INSTR_W-1:0]   out_imm;
  logic [MODE_W-1:0]    out_mode;
  logic [REG_W-1:0]     out_rs;
  logic [REG_W-1:0]     out_rt;

  // Pipeline side: supplies instructions, hazard info and EX acceptance.
  modport master (
    output in_valid, in_instr, flush, ex_memread, ex_rt, out_ready,
    input  in_ready, out_valid, out_imm, out_mode, out_rs, out_rt
  );

  // Controller side.
  modport slave (
    input  in_valid, in_instr, flush, ex_memread, ex_rt, out_ready,
    output in_ready, out_valid, out_imm, out_mode, out_rs, out_rt
  );
endinterface

// File: rtl/imm_decode_ctrl.sv
// ID-stage immediate-extension controller: decodes the extension mode from the
// opcode, registers the extended immediate and register fields into ID/EX,
// inserts load-use bubbles and honours flush.
// Optional: define IMM_DECODE_STALL_COUNT_EN to add a saturating stall_count port.
module imm_decode_ctrl #(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned REG_W            = 5
) (
  input  logic Clk,
  input  logic Reset,
`ifdef IMM_DECODE_STALL_COUNT_EN
  output logic [15:0] stall_count,
`endif
  imm_decode_ctrl_if.slave bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MODE_W = 3;
  localparam int unsigned CNT_W  = 2;
  localparam logic [CNT_W-1:0] BUBBLE_INIT  = CNT_W'(LOAD_USE_BUBBLES - 1);
  localparam logic             MULTI_BUBBLE = (LOAD_USE_BUBBLES > 1);

  typedef enum logic [MODE_W-1:0] {
    MODE_NONE = 3'd0,
    MODE_SIGN = 3'd1,
    MODE_ZERO = 3'd2,
    MODE_LUI  = 3'd3,
    MODE_JUMP = 3'd4
  } mode_e;

  typedef enum logic {
    ST_RUN,
    ST_BUBBLE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [REG_W-1:0]    rs_q, rs_d;
  logic [REG_W-1:0]    rt_q, rt_d;

  logic [5:0]          opcode;
  logic [15:0]         imm16;
  logic [REG_W-1:0]    instr_rs;
  logic [REG_W-1:0]    instr_rt;
  mode_e               dec_mode;
  logic [DATA_W-1:0]   dec_imm;
  logic                uses_rt;
  logic                hazard;
  logic                can_advance;
  logic                in_ready_c;

  assign opcode   = bus.in_instr[31:26];
  assign imm16    = bus.in_instr[15:0];
  assign instr_rs = REG_W'(bus.in_instr[25:21]);
  assign instr_rt = REG_W'(bus.in_instr[20:16]);

  // Extension mode and extended immediate from the opcode (pure wiring).
  always_comb begin
    dec_mode = MODE_SIGN;
    dec_imm  = {{16{imm16[15]}}, imm16};
    unique case (opcode)
      6'h00: begin
        dec_mode = MODE_NONE;
        dec_imm  = '0;
      end
      6'h0C, 6'h0D, 6'h0E: begin
        dec_mode = MODE_ZERO;
        dec_imm  = {16'h0000, imm16};
      end
      6'h0F: begin
        dec_mode = MODE_LUI;
        dec_imm  = {imm16, 16'h0000};
      end
      6'h02, 6'h03: begin
        dec_mode = MODE_JUMP;
        dec_imm  = {6'b0, bus.in_instr[25:0]};
      end
      default: begin
        dec_mode = MODE_SIGN;
        dec_imm  = {{16{imm16[15]}}, imm16};
      end
    endcase
  end

  // Load-use hazard: rt only matters for opcodes that read it as a source.
  always_comb begin
    uses_rt = 1'b0;
    case (opcode)
      6'h00, 6'h04, 6'h05, 6'h2B, 6'h29, 6'h28: uses_rt = 1'b1;
      default:                                  uses_rt = 1'b0;
    endcase
    hazard = bus.in_valid & bus.ex_memread & (bus.ex_rt != '0) &
             ((bus.ex_rt == instr_rs) | ((bus.ex_rt == instr_rt) & uses_rt));
  end

  assign can_advance = ~out_valid_q | bus.out_ready;

  // Next-state and handshake: flush beats hazard beats transfer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    imm_d       = imm_q;
    mode_d      = mode_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    in_ready_c  = 1'b0;

    if (bus.flush) begin
      out_valid_d = 1'b0;
      state_d     = ST_RUN;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (hazard) begin
            if (can_advance) begin
              out_valid_d = 1'b0;
              cnt_d       = BUBBLE_INIT;
              state_d     = MULTI_BUBBLE ? ST_BUBBLE : ST_RUN;
            end
          end else if (can_advance) begin
            in_ready_c = Reset;
            if (bus.in_valid) begin
              out_valid_d = 1'b1;
              imm_d       = dec_imm;
              mode_d      = dec_mode;
              rs_d        = instr_rs;
              rt_d        = instr_rt;
            end else begin
              out_valid_d = 1'b0;
            end
          end
        end
        ST_BUBBLE: begin
          out_valid_d = 1'b0;
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and ID/EX register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      mode_q      <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      imm_q       <= imm_d;
      mode_q      <= mode_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = imm_q;
  assign bus.out_mode  = mode_q;
  assign bus.out_rs    = rs_q;
  assign bus.out_rt    = rt_q;

`ifdef IMM_DECODE_STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of cycles where a valid instruction is held off.
  always_comb begin
    stall_d = stall_q;
    if (bus.in_valid && !in_ready_c && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stall counter register; only reset clears it.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  // Stall counter not built in this configuration.
`endif

endmodule
